// File: rtl/rd_ddr_buf_pkg.sv
// Shared types for the DDR read buffer: FSM state encoding and beat/lane geometry.
package rd_ddr_buf_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, REQ, FLUSH} state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;
endpackage

// File: rtl/rd_ddr_buf_ram.sv
// Simple dual-port beat storage: one write port, one read port with a registered (1-cycle) read.
module rd_ddr_buf_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rd_ddr_buf.sv
// DDR read buffer: credit-checked burst requests, beat buffering and 4:1 lane serialisation.
// Optional stall statistics are enabled by defining RD_DDR_BUF_STAT_EN.
module rd_ddr_buf
  import rd_ddr_buf_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = 256,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int DEPTH_WIDTH    = 9,
  parameter int BURST_LEN      = 16,
  parameter int ADDR_WIDTH     = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [15:0]               total_beats,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [ADDR_WIDTH-1:0]     req_addr,
  output logic [7:0]                req_len,
  input  logic                      ddr_rvalid,
  input  logic [DDR_DATA_WIDTH-1:0] ddr_rdata,
  input  logic                      ddr_rlast,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      done,
  output logic [DEPTH_WIDTH:0]      water_level,
  output logic [15:0]               stall_cnt
);
  localparam int PW = DEPTH_WIDTH + 1;
  localparam logic [16:0] CAP = 17'(1) << DEPTH_WIDTH;

  state_t state, state_nxt;
  logic [15:0]               rem_beats;
  logic [PW-1:0]             outstanding, wr_ptr, rd_ptr, ld_ptr, ld_ptr_nxt;
  logic [LANE_W-1:0]         ld_lane;
  logic                      data_ok, out_last;
  logic [DDR_DATA_WIDTH-1:0] ram_rdata;
  logic [7:0]                burst;
  logic [16:0]               free_space;
  logic                      free_ok, flush_ok, req_hs, beat_in, load, out_take, done_set;
  logic                      unused_rlast;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // a producer holds valid and its payload stable until that cycle.
  assign req_hs   = req_valid && req_ready;
  assign out_take = out_valid && out_ready;
  assign beat_in  = ddr_rvalid && (state != IDLE);
  assign unused_rlast = ddr_rlast;

  assign burst      = (rem_beats > 16'(BURST_LEN)) ? 8'(BURST_LEN) : rem_beats[7:0];
  assign free_space = CAP - 17'(water_level) - 17'(outstanding);
  assign free_ok    = free_space >= 17'(burst);
  assign flush_ok   = (outstanding == '0) && (wr_ptr == rd_ptr);
  assign water_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && total_beats != 16'd0) state_nxt = CHECK;
      CHECK:   if (free_ok) state_nxt = REQ;
      REQ:     if (req_ready) state_nxt = (rem_beats == 16'(req_len)) ? FLUSH : CHECK;
      FLUSH:   if (flush_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    req_valid = (state == REQ);
    done_set  = ((state == IDLE) && start && (total_beats == 16'd0)) ||
                ((state == FLUSH) && flush_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr    <= '0;
      req_len     <= '0;
      rem_beats   <= '0;
      outstanding <= '0;
      done        <= 1'b0;
    end else begin
      done <= done_set;
      if ((state == IDLE) && start && (total_beats != 16'd0)) begin
        req_addr  <= base_addr;
        rem_beats <= total_beats;
      end
      if ((state == CHECK) && free_ok) req_len <= burst;
      if (req_hs) begin
        req_addr  <= req_addr + ADDR_WIDTH'(req_len);
        rem_beats <= rem_beats - 16'(req_len);
      end
      outstanding <= outstanding + (req_hs ? PW'(req_len) : '0) - PW'(beat_in);
    end
  end

  // The read port always addresses the beat being serialised; data_ok says whether the
  // registered RAM output already holds a written beat for that address.
  assign load       = data_ok && (!out_valid || out_ready);
  assign ld_ptr_nxt = (load && ld_lane == LANE_W'(LANES - 1)) ? ld_ptr + PW'(1) : ld_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ld_ptr    <= '0;
      ld_lane   <= '0;
      data_ok   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (beat_in) wr_ptr <= wr_ptr + PW'(1);
      if (out_take && out_last) rd_ptr <= rd_ptr + PW'(1);
      ld_ptr  <= ld_ptr_nxt;
      data_ok <= (ld_ptr_nxt != wr_ptr);
      if (load) begin
        out_data  <= ram_rdata[ld_lane*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
        out_valid <= 1'b1;
        out_last  <= (ld_lane == LANE_W'(LANES - 1));
        ld_lane   <= ld_lane + LANE_W'(1);
      end else if (out_take) begin
        out_valid <= 1'b0;
      end
    end
  end

  rd_ddr_buf_ram #(
    .DATA_WIDTH(DDR_DATA_WIDTH),
    .ADDR_WIDTH(DEPTH_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (beat_in),
    .waddr(wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata(ddr_rdata),
    .raddr(ld_ptr_nxt[DEPTH_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

`ifdef RD_DDR_BUF_STAT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stall_q <= '0;
    else if ((state == IDLE) && start)             stall_q <= '0;
    else if (busy && out_ready && !out_valid && stall_q != 16'hFFFF)
                                                   stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
